// File: rtl/fcims_pkg.sv
// Shared types and widths for the food-court billing controller and its
// accumulator.
package fcims_pkg;

    typedef enum logic [1:0] {
        ACCEPT  = 2'd0,
        APPLY   = 2'd1,
        PRESENT = 2'd2
    } state_t;

    localparam logic OP_SELL    = 1'b1;
    localparam logic OP_RESTOCK = 1'b0;

    localparam int PRICE_W = 4;
    localparam int QTY_W   = 4;
    localparam int STOCK_W = 4;
    localparam int LINE_W  = 8;

    localparam logic [STOCK_W-1:0] STOCK_MAX = 4'd15;

endpackage

// File: rtl/fcims_bill_accum.sv
// Per-transaction bill accumulator: saturating bill, saturating 4-bit count
// of accepted sales, and a sticky overflow flag, all cleared at checkout.
module fcims_bill_accum
    import fcims_pkg::*;
#(
    parameter int BILL_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              add_en,
    input  logic              inc_item,
    input  logic [LINE_W-1:0] add_val,
    output logic [BILL_W-1:0] bill,
    output logic [3:0]        items,
    output logic              ovf
);

    localparam logic [BILL_W:0] BILL_MAX = {1'b0, {BILL_W{1'b1}}};

    logic [BILL_W:0] sum;

    assign sum = {1'b0, bill} + {{(BILL_W + 1 - LINE_W){1'b0}}, add_val};

    // Reaching the ceiling counts as saturation, so ovf flags any bill pinned at max.
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            bill  <= '0;
            items <= '0;
            ovf   <= 1'b0;
        end else begin
            if (add_en) begin
                if (sum >= BILL_MAX) begin
                    bill <= BILL_MAX[BILL_W-1:0];
                    ovf  <= 1'b1;
                end else begin
                    bill <= sum[BILL_W-1:0];
                end
            end
            if (inc_item && (items != 4'hF)) begin
                items <= items + 4'd1;
            end
        end
    end

endmodule

// File: rtl/fcims_billing_ctrl.sv
// Sequences line items through the external price/stock datapath, owns the
// stock register, and presents the transaction bill over valid/ready.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ACCEPT  | idle, takes an item or a checkout request
// APPLY   | datapath driven with the latched item, results captured
// PRESENT | bill total held until the consumer takes it
module fcims_billing_ctrl
    import fcims_pkg::*;
#(
    parameter int INIT_STOCK = 0,
    parameter int BILL_W     = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               item_valid,
    output logic               item_ready,
    input  logic               item_op,
    input  logic [PRICE_W-1:0] item_uprice,
    input  logic [QTY_W-1:0]   item_qty,
    output logic               item_ack,
    output logic               item_err,
    input  logic               checkout,
    output logic               total_valid,
    input  logic               total_ready,
    output logic [BILL_W-1:0]  total_bill,
    output logic [3:0]         total_items,
    output logic               bill_ovf,
    output logic [STOCK_W-1:0] stock,
    output logic               fc_reset,
    output logic               fc_ctrl,
    output logic [PRICE_W-1:0] fc_uprice,
    output logic [QTY_W-1:0]   fc_ncel,
    output logic [STOCK_W-1:0] fc_ct,
    input  logic [STOCK_W-1:0] fc_new_ct,
    input  logic [LINE_W-1:0]  fc_fprice
);

    state_t               state_q, state_d;
    logic                 op_q;
    logic [PRICE_W-1:0]   uprice_q;
    logic [QTY_W-1:0]     qty_q;
    logic [STOCK_W-1:0]   stock_q;
    logic                 ack_q, err_q;

    logic [STOCK_W:0]     stock_x, qty_x, restock_sum;
    logic                 sell_bad, restock_bad, item_bad;
    logic                 in_apply, accept_item, legal_sell;

    assign in_apply    = (state_q == APPLY);
    assign accept_item = (state_q == ACCEPT) && item_valid;

    // Legality is judged locally so a wrapping datapath result is never committed.
    assign stock_x     = {1'b0, stock_q};
    assign qty_x       = {1'b0, qty_q};
    assign restock_sum = stock_x + qty_x;
    assign sell_bad    = (op_q == OP_SELL) && (qty_x > stock_x);
    assign restock_bad = (op_q == OP_RESTOCK) && (restock_sum > {1'b0, STOCK_MAX});
    assign item_bad    = sell_bad || restock_bad;
    assign legal_sell  = in_apply && !item_bad && (op_q == OP_SELL);

    always_comb begin
        state_d     = state_q;
        item_ready  = 1'b0;
        total_valid = 1'b0;
        fc_reset    = 1'b1;
        fc_ctrl     = 1'b0;
        fc_uprice   = '0;
        fc_ncel     = '0;
        fc_ct       = '0;
        case (state_q)
            ACCEPT: begin
                item_ready = reset;
                if (item_valid) begin
                    state_d = APPLY;
                end else if (checkout) begin
                    state_d = PRESENT;
                end
            end
            APPLY: begin
                fc_reset  = 1'b0;
                fc_ctrl   = op_q;
                fc_uprice = (op_q == OP_SELL) ? uprice_q : '0;
                fc_ncel   = qty_q;
                fc_ct     = stock_q;
                state_d   = ACCEPT;
            end
            PRESENT: begin
                total_valid = 1'b1;
                if (total_ready) begin
                    state_d = ACCEPT;
                end
            end
            default: state_d = ACCEPT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ACCEPT;
            op_q     <= OP_RESTOCK;
            uprice_q <= '0;
            qty_q    <= '0;
            stock_q  <= STOCK_W'(INIT_STOCK);
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= in_apply;
            err_q   <= in_apply && item_bad;
            if (accept_item) begin
                op_q     <= item_op;
                uprice_q <= item_uprice;
                qty_q    <= item_qty;
            end
            if (in_apply && !item_bad) begin
                stock_q <= fc_new_ct;
            end
        end
    end

    fcims_bill_accum #(
        .BILL_W (BILL_W)
    ) u_accum (
        .clk      (clk),
        .reset    (reset),
        .clear    (total_valid && total_ready),
        .add_en   (legal_sell),
        .inc_item (legal_sell && (qty_q != '0)),
        .add_val  (fc_fprice),
        .bill     (total_bill),
        .items    (total_items),
        .ovf      (bill_ovf)
    );

    assign item_ack = ack_q;
    assign item_err = err_q;
    assign stock    = stock_q;

endmodule

// File: tb/tb_fcims_billing_ctrl.sv
// Directed bench for fcims_billing_ctrl with a behavioural stand-in for the
// external price/stock datapath.
module tb_fcims_billing_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       item_valid, item_op, checkout, total_ready;
    logic [3:0] item_uprice, item_qty;
    logic       item_ready, item_ack, item_err, total_valid, bill_ovf;
    logic [7:0] total_bill;
    logic [3:0] total_items, stock;
    logic       fc_reset, fc_ctrl;
    logic [3:0] fc_uprice, fc_ncel, fc_ct, fc_new_ct;
    logic [7:0] fc_fprice;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // External datapath: count add/sub and unit price times quantity.
    always_comb begin
        if (fc_reset) begin
            fc_new_ct = 4'd0;
            fc_fprice = 8'd0;
        end else begin
            fc_new_ct = fc_ctrl ? (fc_ct - fc_ncel) : (fc_ct + fc_ncel);
            fc_fprice = 8'(fc_uprice) * 8'(fc_ncel);
        end
    end

    fcims_billing_ctrl #(
        .INIT_STOCK (0),
        .BILL_W     (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .item_valid  (item_valid),
        .item_ready  (item_ready),
        .item_op     (item_op),
        .item_uprice (item_uprice),
        .item_qty    (item_qty),
        .item_ack    (item_ack),
        .item_err    (item_err),
        .checkout    (checkout),
        .total_valid (total_valid),
        .total_ready (total_ready),
        .total_bill  (total_bill),
        .total_items (total_items),
        .bill_ovf    (bill_ovf),
        .stock       (stock),
        .fc_reset    (fc_reset),
        .fc_ctrl     (fc_ctrl),
        .fc_uprice   (fc_uprice),
        .fc_ncel     (fc_ncel),
        .fc_ct       (fc_ct),
        .fc_new_ct   (fc_new_ct),
        .fc_fprice   (fc_fprice)
    );

    typedef struct {
        logic       op;
        logic [3:0] uprice;
        logic [3:0] qty;
        logic       err;
        logic [3:0] stock;
        logic [7:0] bill;
        logic [3:0] items;
        logic       ovf;
        int         hold;   // -1: no checkout after item; else total_ready hold cycles
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_item(input vec_t v, input logic [3:0] prev_stock);
        int n;
        n = 0;
        @(negedge clk);
        while (!item_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!item_ready) chk("item_ready_timeout", 0, 1);
        item_valid  = 1'b1;
        item_op     = v.op;
        item_uprice = v.uprice;
        item_qty    = v.qty;
        @(negedge clk);
        item_valid = 1'b0;
        chk("apply_item_ready", item_ready, 0);
        chk("apply_fc_reset", fc_reset, 0);
        chk("apply_fc_ctrl", fc_ctrl, v.op);
        chk("apply_fc_uprice", fc_uprice, v.op ? v.uprice : 4'd0);
        chk("apply_fc_ncel", fc_ncel, v.qty);
        chk("apply_fc_ct", fc_ct, prev_stock);
        @(negedge clk);
        chk("item_ack", item_ack, 1);
        chk("item_err", item_err, v.err);
        chk("stock", stock, v.stock);
        chk("bill", total_bill, v.bill);
        chk("items", total_items, v.items);
        chk("ovf", bill_ovf, v.ovf);
        chk("fc_reset_idle", fc_reset, 1);
    endtask

    task automatic do_checkout(input int hold, input logic [7:0] eb,
                               input logic [3:0] ei, input logic eo);
        @(negedge clk);
        checkout = 1'b1;
        @(negedge clk);
        checkout = 1'b0;
        chk("present_valid", total_valid, 1);
        chk("present_bill", total_bill, eb);
        chk("present_items", total_items, ei);
        chk("present_ovf", bill_ovf, eo);
        chk("present_item_ready", item_ready, 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", total_valid, 1);
            chk("hold_bill", total_bill, eb);
            chk("hold_items", total_items, ei);
        end
        total_ready = 1'b1;
        @(negedge clk);
        total_ready = 1'b0;
        chk("done_valid", total_valid, 0);
        chk("done_item_ready", item_ready, 1);
        chk("clr_bill", total_bill, 0);
        chk("clr_items", total_items, 0);
        chk("clr_ovf", bill_ovf, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] prev;
        //            op    pr     qty    err   stock  bill    it     ovf  hold
        vecs[0]  = '{1'b0, 4'd0,  4'd10, 1'b0, 4'd10, 8'd0,   4'd0, 1'b0, -1};
        vecs[1]  = '{1'b1, 4'd7,  4'd3,  1'b0, 4'd7,  8'd21,  4'd1, 1'b0, -1};
        vecs[2]  = '{1'b1, 4'd9,  4'd8,  1'b1, 4'd7,  8'd21,  4'd1, 1'b0, -1};
        vecs[3]  = '{1'b1, 4'd5,  4'd0,  1'b0, 4'd7,  8'd21,  4'd1, 1'b0, -1};
        vecs[4]  = '{1'b0, 4'd6,  4'd5,  1'b0, 4'd12, 8'd21,  4'd1, 1'b0, -1};
        vecs[5]  = '{1'b0, 4'd0,  4'd4,  1'b1, 4'd12, 8'd21,  4'd1, 1'b0, -1};
        vecs[6]  = '{1'b0, 4'd0,  4'd3,  1'b0, 4'd15, 8'd21,  4'd1, 1'b0,  5};
        vecs[7]  = '{1'b1, 4'd1,  4'd10, 1'b0, 4'd5,  8'd10,  4'd1, 1'b0, -1};
        vecs[8]  = '{1'b1, 4'd2,  4'd6,  1'b1, 4'd5,  8'd10,  4'd1, 1'b0,  0};
        vecs[9]  = '{1'b0, 4'd0,  4'd10, 1'b0, 4'd15, 8'd0,   4'd0, 1'b0, -1};
        vecs[10] = '{1'b1, 4'd15, 4'd15, 1'b0, 4'd0,  8'd225, 4'd1, 1'b0, -1};
        vecs[11] = '{1'b0, 4'd0,  4'd15, 1'b0, 4'd15, 8'd225, 4'd1, 1'b0, -1};
        vecs[12] = '{1'b1, 4'd15, 4'd2,  1'b0, 4'd13, 8'd255, 4'd2, 1'b1,  0};

        reset = 1'b0;
        item_valid = 1'b0; item_op = 1'b0; item_uprice = 4'd0; item_qty = 4'd0;
        checkout = 1'b0; total_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_item_ready", item_ready, 0);
        chk("rst_item_ack", item_ack, 0);
        chk("rst_total_valid", total_valid, 0);
        chk("rst_bill", total_bill, 0);
        chk("rst_items", total_items, 0);
        chk("rst_ovf", bill_ovf, 0);
        chk("rst_stock", stock, 0);
        chk("rst_fc_reset", fc_reset, 1);
        chk("rst_fc_ncel", fc_ncel, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_item_ready", item_ready, 1);

        prev = 4'd0;
        for (int i = 0; i < 13; i++) begin
            do_item(vecs[i], prev);
            prev = vecs[i].stock;
            if (vecs[i].hold >= 0)
                do_checkout(vecs[i].hold, vecs[i].bill, vecs[i].items, vecs[i].ovf);
        end

        // Item and checkout together: item wins, checkout seen two cycles later.
        @(negedge clk);
        item_valid = 1'b1; item_op = 1'b1; item_uprice = 4'd1; item_qty = 4'd1;
        checkout = 1'b1;
        @(negedge clk);
        item_valid = 1'b0;
        chk("prio_apply_valid", total_valid, 0);
        chk("prio_apply_ready", item_ready, 0);
        @(negedge clk);
        chk("prio_ack", item_ack, 1);
        chk("prio_not_present", total_valid, 0);
        chk("prio_stock", stock, 12);
        @(negedge clk);
        checkout = 1'b0;
        chk("prio_present", total_valid, 1);
        chk("prio_bill", total_bill, 1);
        chk("prio_items", total_items, 1);
        total_ready = 1'b1;
        @(negedge clk);
        total_ready = 1'b0;
        chk("prio_done", total_valid, 0);
        chk("prio_clr_bill", total_bill, 0);

        // Reset during APPLY aborts the item.
        @(negedge clk);
        item_valid = 1'b1; item_op = 1'b0; item_uprice = 4'd0; item_qty = 4'd1;
        @(negedge clk);
        item_valid = 1'b0;
        chk("rstmid_fc_reset", fc_reset, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("rstmid_no_ack", item_ack, 0);
        chk("rstmid_stock", stock, 0);
        chk("rstmid_ready_low", item_ready, 0);
        chk("rstmid_fc_reset_idle", fc_reset, 1);
        @(negedge clk);
        chk("rstmid_still_no_ack", item_ack, 0);
        reset = 1'b1;
        #1;
        chk("rstmid_ready_high", item_ready, 1);
        @(negedge clk);
        chk("rstmid_stock_after", stock, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fcims_billing_ctrl.md
# fcims_billing_ctrl

Sequential controller that drives the combinational food-court item/stock datapath (price multiplier plus stock adder/subtracter) and consumes its results. It holds the registered stock count, sequences one line item at a time through the datapath, and rejects sales that exceed stock or restocks that overflow it. It accumulates the per-transaction bill and presents the total at checkout over a valid/ready handshake.

## Interface
Parameters:
- INIT_STOCK, 0, stock register value after reset (0..15)
- BILL_W, 12, bill accumulator width

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-low; all registers take reset values on a clk edge while low
- item_valid  in  1  line item offered
- item_ready  out  1  block can accept an item this cycle
- item_op  in  1  1 = sell, 0 = restock
- item_uprice  in  4  unit price (sell only)
- item_qty  in  4  quantity
- item_ack  out  1  one-cycle pulse when an item finishes
- item_err  out  1  valid with item_ack; 1 = item rejected
- checkout  in  1  level request to close the transaction
- total_valid  out  1  bill total presented
- total_ready  in  1  consumer takes total
- total_bill  out  BILL_W  accumulated bill
- total_items  out  4  number of accepted non-zero sales
- bill_ovf  out  1  bill saturated this transaction
- stock  out  4  current stock register
- fc_reset  out  1  datapath reset (active-high) control
- fc_ctrl  out  1  datapath add/sub select
- fc_uprice  out  4  datapath unit price
- fc_ncel  out  4  datapath quantity
- fc_ct  out  4  datapath current count
- fc_new_ct  in  4  datapath updated count
- fc_fprice  in  8  datapath line price

## Operation
- States: ACCEPT, APPLY, PRESENT. Reset enters ACCEPT.
- ACCEPT: item_ready=1. item_valid=1 latches op/uprice/qty, next state APPLY. Else checkout=1 goes to PRESENT. item_valid has priority over a simultaneous checkout; checkout is re-sampled on a later ACCEPT cycle.
- APPLY: item_ready=0. The block drives fc_reset=0, fc_ctrl=op, fc_uprice=latched price (forced to 0 for restock), fc_ncel=qty, fc_ct=stock.
  - Legality is checked locally on 5-bit arithmetic. A sell with qty>stock is an error. A restock with stock+qty>15 is an error.
  - Legal item: stock<=fc_new_ct. For a sell, the bill adds zero-extended fc_fprice; if qty≠0, total_items increments.
  - Error item: stock, bill and total_items are unchanged.
  - qty=0 is legal and a no-op.
  - item_ack=1 the following cycle with item_err, and the state returns to ACCEPT.
- Bill saturates at 2^BILL_W−1 and sets bill_ovf, which is sticky until the transaction closes. total_items saturates at 15.
- PRESENT: total_valid=1 with stable total_bill, total_items and bill_ovf. On total_valid&&total_ready, the bill, total_items and bill_ovf clear, and the state returns to ACCEPT. Stock persists across transactions. Checkout with no sales presents 0/0.
- Outside APPLY: fc_reset=1 and the other fc_* outputs are 0.
- Reset values: item_ready=0 while reset is low, then 1 in ACCEPT. item_ack=0, item_err=0, total_valid=0, total_bill=0, total_items=0, bill_ovf=0, stock=INIT_STOCK, fc_reset=1, all other fc_* outputs=0.
- Reset low in any state, including mid-APPLY or PRESENT, aborts the operation: no ack, total dropped.

## Timing
- Item accepted at edge N. APPLY occupies cycle N+1, and results are captured at edge N+2. item_ack is high in cycle N+2, which is also an ACCEPT cycle, so a new item can be accepted there.
- Throughput is 1 item per 2 cycles.
- fc_* outputs are registered-state decodes. The fc_new_ct/fc_fprice path is combinational within the APPLY cycle, and the full datapath must meet one cycle.
- PRESENT holds for an unbounded time until total_ready. total_ready=1 on the first PRESENT cycle completes in 1 cycle.

## Structure
- Package fcims_pkg holds:
  - state enum {ACCEPT, APPLY, PRESENT}
  - OP_SELL=1, OP_RESTOCK=0
  - PRICE_W=4, QTY_W=4, STOCK_W=4, LINE_W=8
  - stock max constant 15
- Sub-module fcims_bill_accum holds the saturating BILL_W accumulator, the 4-bit item counter and the sticky overflow, with clear and add-enable inputs.
- The datapath instance sits outside this block, at the next level up.

## Test plan
- Restock and sell: INIT_STOCK=0, restock qty 10 -> ack, err=0, stock=10. Sell price 7 qty 3 -> stock=7. Checkout -> total_bill=21, total_items=1.
- Oversell: stock=5, sell qty 6 -> item_err=1, stock stays 5, bill unchanged.
- Restock overflow: stock=12, restock qty 4 -> err=1. Restock qty 3 -> stock=15.
- Bill saturation (BILL_W=8): sell 15×15 (225) then 15×2 (30), with stock sufficient -> total_bill=255, bill_ovf=1. After handshake -> 0/0/0.
- Priority and backpressure: item_valid and checkout asserted together -> item processed first, PRESENT entered 2 cycles later. Hold total_ready=0 for 5 cycles -> total stable. Assert total_ready -> ACCEPT next cycle.
- Reset mid-APPLY: reset low during APPLY -> no item_ack, stock=INIT_STOCK, item_ready=0 until reset high, then 1.
